// File: rtl/gpio_in_pkg.sv
// Shared constants for the GPIO input peripheral: base address and register offsets.
package gpio_in_pkg;

   localparam logic [31:0] GPIO_IN_BASE = 32'h0000_0500;

   localparam int unsigned GPIO_IN_DATA    = 'h00;
   localparam int unsigned GPIO_IN_RAW     = 'h04;
   localparam int unsigned GPIO_IN_RISE_EN = 'h08;
   localparam int unsigned GPIO_IN_FALL_EN = 'h0C;
   localparam int unsigned GPIO_IN_PENDING = 'h10;
   localparam int unsigned GPIO_IN_IRQ_EN  = 'h14;

endpackage

// File: rtl/gpio_debounce.sv
// One input pin: 2-FF synchronizer followed by a consecutive-cycle debouncer.
// The edge pulses are combinational and fire on the clock edge where stable changes.
module gpio_debounce
   import gpio_in_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic sync,
   output logic stable,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic [CW-1:0] cnt_q;
   logic          accept;

   // The counter would reach DEBOUNCE_CYCLES on this edge, so take the new level now.
   assign accept = (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q <= pin;
         sync2_q <= sync1_q;
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (accept) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign sync       = sync2_q;
   assign stable     = stable_q;
   assign rise_pulse = accept & sync2_q;
   assign fall_pulse = accept & ~sync2_q;

endmodule

// File: rtl/gpio_in.sv
// Memory-mapped GPIO input block: per-pin debouncers, edge-enable/pending/irq-enable
// registers with W1C pending, a registered read mux and a registered level interrupt.
module gpio_in
   import gpio_in_pkg::*;
#(
   parameter int unsigned NUM_PINS        = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned ADDR_W          = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_PINS-1:0] pins,
   input  logic                r_en,
   input  logic [31:0]         r_addr,
   output logic [31:0]         r_data,
   input  logic                w_en,
   input  logic [31:0]         w_addr,
   input  logic [31:0]         w_data,
   output logic                irq
);

   logic [NUM_PINS-1:0] sync_v;
   logic [NUM_PINS-1:0] stable_v;
   logic [NUM_PINS-1:0] rise_v;
   logic [NUM_PINS-1:0] fall_v;

   for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
      gpio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk       (clk),
         .rst       (rst),
         .pin       (pins[i]),
         .sync      (sync_v[i]),
         .stable    (stable_v[i]),
         .rise_pulse(rise_v[i]),
         .fall_pulse(fall_v[i])
      );
   end

   logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
   logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
   logic [NUM_PINS-1:0] pending_q, pending_d;
   logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
   logic [NUM_PINS-1:0] w1c;
   logic [NUM_PINS-1:0] set_v;
   logic [ADDR_W-1:0]   r_off;
   logic [ADDR_W-1:0]   w_off;
   logic [31:0]         rd_val;
   logic                unused_bits;

   assign r_off       = r_addr[ADDR_W-1:0];
   assign w_off       = w_addr[ADDR_W-1:0];
   assign set_v       = (rise_v & rise_en_q) | (fall_v & fall_en_q);
   assign unused_bits = ^{r_addr, w_addr, w_data};

   always_comb begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      irq_en_d  = irq_en_q;
      w1c       = '0;
      if (w_en) begin
         case (w_off)
            ADDR_W'(GPIO_IN_RISE_EN): rise_en_d = w_data[NUM_PINS-1:0];
            ADDR_W'(GPIO_IN_FALL_EN): fall_en_d = w_data[NUM_PINS-1:0];
            ADDR_W'(GPIO_IN_PENDING): w1c       = w_data[NUM_PINS-1:0];
            ADDR_W'(GPIO_IN_IRQ_EN):  irq_en_d  = w_data[NUM_PINS-1:0];
            default: ;
         endcase
      end
      // A new edge in the same cycle as its W1C keeps the bit set.
      pending_d = (pending_q & ~w1c) | set_v;
   end

   always_comb begin
      rd_val = '0;
      case (r_off)
         ADDR_W'(GPIO_IN_DATA):    rd_val = 32'(stable_v);
         ADDR_W'(GPIO_IN_RAW):     rd_val = 32'(sync_v);
         ADDR_W'(GPIO_IN_RISE_EN): rd_val = 32'(rise_en_q);
         ADDR_W'(GPIO_IN_FALL_EN): rd_val = 32'(fall_en_q);
         ADDR_W'(GPIO_IN_PENDING): rd_val = 32'(pending_q);
         ADDR_W'(GPIO_IN_IRQ_EN):  rd_val = 32'(irq_en_q);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_en_q <= '0;
         fall_en_q <= '0;
         pending_q <= '0;
         irq_en_q  <= '0;
         r_data    <= '0;
         irq       <= 1'b0;
      end else begin
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pending_q <= pending_d;
         irq_en_q  <= irq_en_d;
         r_data    <= r_en ? rd_val : 32'h0;
         irq       <= |(pending_q & irq_en_q);
      end
   end

endmodule

// File: tb/tb_gpio_in.sv
// Directed bench for gpio_in with DEBOUNCE_CYCLES=4: register-map tables plus
// hand-timed sequences for debounce, edge detection, W1C races and reset.
module tb_gpio_in;

   localparam int unsigned NP = 8;
   localparam int unsigned DC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] pins;
   logic          r_en;
   logic [31:0]   r_addr;
   logic [31:0]   r_data;
   logic          w_en;
   logic [31:0]   w_addr;
   logic [31:0]   w_data;
   logic          irq;

   int errors = 0;
   int checks = 0;

   gpio_in #(
      .NUM_PINS       (NP),
      .DEBOUNCE_CYCLES(DC),
      .ADDR_W         (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .pins  (pins),
      .r_en  (r_en),
      .r_addr(r_addr),
      .r_data(r_data),
      .w_en  (w_en),
      .w_addr(w_addr),
      .w_data(w_data),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        do_wr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      r_en   = 1'b1;
      r_addr = a;
      step();
      d      = r_data;
      r_en   = 1'b0;
      r_addr = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      w_en   = 1'b1;
      w_addr = a;
      w_data = d;
      step();
      w_en   = 1'b0;
      w_addr = '0;
      w_data = '0;
   endtask

   task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   vec_t rst_tab[9];
   vec_t rw_tab[7];

   initial begin
      logic [31:0] d;

      rst_tab[0] = '{32'h00, 1'b0, 32'h0, 32'h0};
      rst_tab[1] = '{32'h04, 1'b0, 32'h0, 32'h0};
      rst_tab[2] = '{32'h08, 1'b0, 32'h0, 32'h0};
      rst_tab[3] = '{32'h0C, 1'b0, 32'h0, 32'h0};
      rst_tab[4] = '{32'h10, 1'b0, 32'h0, 32'h0};
      rst_tab[5] = '{32'h14, 1'b0, 32'h0, 32'h0};
      rst_tab[6] = '{32'h18, 1'b0, 32'h0, 32'h0};
      rst_tab[7] = '{32'hFF, 1'b0, 32'h0, 32'h0};
      rst_tab[8] = '{32'h508, 1'b0, 32'h0, 32'h0};

      // Pins are settled at 0x07 while this table runs, so no edges fire.
      rw_tab[0] = '{32'h08, 1'b1, 32'hFFFF_FF00, 32'h00};
      rw_tab[1] = '{32'h0C, 1'b1, 32'hFFFF_FFA5, 32'hA5};
      rw_tab[2] = '{32'h14, 1'b1, 32'h0000_003C, 32'h3C};
      rw_tab[3] = '{32'h508, 1'b1, 32'h0000_005A, 32'h5A};
      rw_tab[4] = '{32'h1C, 1'b1, 32'hFFFF_FFFF, 32'h00};
      rw_tab[5] = '{32'h04, 1'b1, 32'hFFFF_FFFF, 32'h07};
      rw_tab[6] = '{32'hABCD_0014, 1'b1, 32'h0000_0000, 32'h00};

      rst    = 1'b1;
      pins   = '0;
      r_en   = 1'b0;
      r_addr = '0;
      w_en   = 1'b0;
      w_addr = '0;
      w_data = '0;
      repeat (3) step();
      check("rst_rdata", r_data, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      rst = 1'b0;

      foreach (rst_tab[i]) begin
         rd(rst_tab[i].addr, d);
         check($sformatf("reset_read[%0d]", i), d, rst_tab[i].exp);
      end
      check("reset_irq", {31'h0, irq}, 32'h0);

      // Level 0x05 applied before edge E1: RAW after E2, DATA after E6.
      pins = 8'h05;
      step();
      rd_check("raw_before_sync", 32'h04, 32'h00);
      rd_check("raw_after_sync", 32'h04, 32'h05);
      step();
      step();
      rd_check("data_before_accept", 32'h00, 32'h00);
      rd_check("data_after_accept", 32'h00, 32'h05);
      step();
      check("rdata_idle_zero", r_data, 32'h0);

      // Pin 3 high for only 3 sampled cycles: visible in RAW, rejected by the debouncer.
      pins = 8'h0D;
      step();
      step();
      rd_check("glitch_raw", 32'h04, 32'h0D);
      pins = 8'h05;
      rd_check("glitch_data_mid", 32'h00, 32'h05);
      repeat (6) step();
      rd_check("glitch_data_after", 32'h00, 32'h05);
      rd_check("glitch_pending", 32'h10, 32'h00);

      // Rising edge on pin 1 with rise and irq enabled.
      wr(32'h08, 32'h02);
      wr(32'h14, 32'h02);
      pins = 8'h07;
      repeat (6) step();
      check("irq_on_set_edge", {31'h0, irq}, 32'h0);
      rd_check("rise_pending", 32'h10, 32'h02);
      check("irq_one_after", {31'h0, irq}, 32'h1);
      wr(32'h10, 32'h02);
      check("irq_still_on_w1c_edge", {31'h0, irq}, 32'h1);
      step();
      check("irq_cleared", {31'h0, irq}, 32'h0);
      rd_check("pending_cleared", 32'h10, 32'h00);

      // Falling edge on pin 7 with a W1C landing on the set edge: set wins.
      wr(32'h14, 32'h00);
      pins = 8'h87;
      repeat (8) step();
      rd_check("pin7_high_no_pending", 32'h10, 32'h00);
      wr(32'h0C, 32'h80);
      pins = 8'h07;
      repeat (5) step();
      wr(32'h10, 32'h80);
      rd_check("set_beats_w1c", 32'h10, 32'h80);
      check("irq_gated_off", {31'h0, irq}, 32'h0);
      wr(32'h0C, 32'h00);
      rd_check("disable_keeps_pending", 32'h10, 32'h80);
      wr(32'h14, 32'h80);
      step();
      check("irq_en_on", {31'h0, irq}, 32'h1);
      wr(32'h14, 32'h00);
      check("irq_en_off_lag", {31'h0, irq}, 32'h1);
      step();
      check("irq_en_off", {31'h0, irq}, 32'h0);

      // Same-cycle read and write of RISE_EN returns the old value.
      r_en   = 1'b1;
      r_addr = 32'h08;
      w_en   = 1'b1;
      w_addr = 32'h08;
      w_data = 32'hFF;
      step();
      check("rw_same_cycle", r_data, 32'h02);
      r_en = 1'b0;
      w_en = 1'b0;
      rd_check("rw_next_read", 32'h08, 32'hFF);
      wr(32'h00, 32'hAA);
      rd_check("data_ro", 32'h00, 32'h07);
      rd_check("pending_untouched", 32'h10, 32'h80);

      foreach (rw_tab[i]) begin
         if (rw_tab[i].do_wr) wr(rw_tab[i].addr, rw_tab[i].wdata);
         rd(rw_tab[i].addr, d);
         check($sformatf("rw_table[%0d]", i), d, rw_tab[i].exp);
      end

      // Reset in the middle of a debounce count, pins held high afterwards.
      pins = 8'h0F;
      repeat (3) step();
      rst = 1'b1;
      #1;
      check("async_rst_rdata", r_data, 32'h0);
      step();
      rst = 1'b0;
      rd_check("post_rst_data_e1", 32'h00, 32'h00);
      repeat (4) step();
      rd_check("post_rst_data_e6", 32'h00, 32'h00);
      rd_check("post_rst_data_e7", 32'h00, 32'h0F);
      rd_check("post_rst_pending", 32'h10, 32'h00);
      rd_check("post_rst_rise_en", 32'h08, 32'h00);
      check("post_rst_irq", {31'h0, irq}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
